// File: rtl/deque_cmd_sequencer.sv
// Command front-end for dual_deque: accepts PUSH/POP/MOVE/NOP over valid/ready, checks the
// empty/full flags, issues one-cycle registered push/pop strobes and returns one response per command.
module deque_cmd_sequencer #(
  parameter int unsigned POP_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_sel,
  input  logic       cmd_end,
  input  logic       cmd_dst_sel,
  input  logic       cmd_dst_end,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       dq_deque_select,
  output logic       dq_end_select,
  output logic       dq_push,
  output logic       dq_pop,
  output logic [7:0] dq_data_in,
  input  logic [7:0] dq_data_out,
  input  logic       d0_empty,
  input  logic       d0_full,
  input  logic       d1_empty,
  input  logic       d1_full
);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_WAIT, S_MV_PUSH, S_RESP} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_PUSH, OP_POP, OP_MOVE} op_t;

  localparam logic [2:0] WAIT_INIT = 3'(POP_LAT - 1);

  state_t     state;
  logic       is_move;
  logic       dst_sel_q;
  logic       dst_end_q;
  logic [2:0] wait_cnt;

  logic accept;
  logic src_empty;
  logic src_full;
  logic dst_full;

  assign accept = cmd_valid & cmd_ready;

  always_comb begin
    src_empty = cmd_sel ? d1_empty : d0_empty;
    src_full  = cmd_sel ? d1_full  : d0_full;
    dst_full  = cmd_dst_sel ? d1_full : d0_full;
  end

  always_ff @(posedge clk) begin
    if (POP_LAT < 1 || POP_LAT > 7) $fatal(1, "deque_cmd_sequencer: POP_LAT must be 1..7");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cmd_ready       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
      rsp_err         <= 1'b0;
      dq_deque_select <= 1'b0;
      dq_end_select   <= 1'b0;
      dq_push         <= 1'b0;
      dq_pop          <= 1'b0;
      dq_data_in      <= '0;
      is_move         <= 1'b0;
      dst_sel_q       <= 1'b0;
      dst_end_q       <= 1'b0;
      wait_cnt        <= '0;
    end else begin
      dq_push <= 1'b0;
      dq_pop  <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            is_move   <= 1'b0;
            dst_sel_q <= cmd_dst_sel;
            dst_end_q <= cmd_dst_end;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            case (op_t'(cmd_op))
              OP_NOP: begin
                state     <= S_RESP;
                rsp_valid <= 1'b1;
              end
              OP_PUSH: begin
                if (src_full) begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                end else begin
                  state           <= S_EXEC;
                  dq_push         <= 1'b1;
                  dq_deque_select <= cmd_sel;
                  dq_end_select   <= cmd_end;
                  dq_data_in      <= cmd_data;
                end
              end
              OP_POP, OP_MOVE: begin
                // A same-deque MOVE frees a slot with its pop, so dst full only matters across deques
                if (src_empty || (op_t'(cmd_op) == OP_MOVE && dst_full && cmd_dst_sel != cmd_sel)) begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                end else begin
                  state           <= S_EXEC;
                  is_move         <= (op_t'(cmd_op) == OP_MOVE);
                  dq_pop          <= 1'b1;
                  dq_deque_select <= cmd_sel;
                  dq_end_select   <= cmd_end;
                  dq_data_in      <= '0;
                end
              end
            endcase
          end
        end
        S_EXEC: begin
          if (dq_pop) begin
            state    <= S_WAIT;
            wait_cnt <= WAIT_INIT;
          end else begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 3'd0) begin
            if (is_move) begin
              state           <= S_MV_PUSH;
              dq_push         <= 1'b1;
              dq_deque_select <= dst_sel_q;
              dq_end_select   <= dst_end_q;
              dq_data_in      <= dq_data_out;
            end else begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= dq_data_out;
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_MV_PUSH: begin
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= dq_data_in;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deque_cmd_sequencer.sv
// Bench for deque_cmd_sequencer: directed vector table, reset corner cases, then random
// commands against a queue-based deque environment and a command-level reference model.
module tb_deque_cmd_sequencer;

  localparam int unsigned POP_LAT = 1;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic       cmd_sel = 1'b0, cmd_end = 1'b0, cmd_dst_sel = 1'b0, cmd_dst_end = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       dq_deque_select, dq_end_select, dq_push, dq_pop;
  logic [7:0] dq_data_in;
  logic [7:0] dq_data_out = '0;
  logic       d0_empty = 1'b1, d0_full = 1'b0, d1_empty = 1'b1, d1_full = 1'b0;

  deque_cmd_sequencer #(.POP_LAT(POP_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sel(cmd_sel),
    .cmd_end(cmd_end), .cmd_dst_sel(cmd_dst_sel), .cmd_dst_end(cmd_dst_end), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dq_deque_select(dq_deque_select), .dq_end_select(dq_end_select),
    .dq_push(dq_push), .dq_pop(dq_pop), .dq_data_in(dq_data_in), .dq_data_out(dq_data_out),
    .d0_empty(d0_empty), .d0_full(d0_full), .d1_empty(d1_empty), .d1_full(d1_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- deque environment ----------------
  logic       auto_mode = 1'b0;
  logic       f_d0e = 1'b1, f_d0f = 1'b0, f_d1e = 1'b1, f_d1f = 1'b0;
  logic [7:0] f_pop_byte = '0;
  logic [7:0] eq0[$];
  logic [7:0] eq1[$];
  int         cyc = 0;
  int         pend_due = -1;
  logic [7:0] pend_val = '0;
  int         push_total = 0, pop_total = 0, both_hi = 0, push_cyc = 0, pop_cyc = 0;
  logic       push_sel = 1'b0, push_end = 1'b0, pop_sel = 1'b0, pop_end = 1'b0;
  logic [7:0] push_dat = '0;

  // Popped byte appears on dq_data_out exactly POP_LAT cycles after the strobe, junk otherwise
  always @(posedge clk) begin
    cyc++;
    #1;
    if (cyc == pend_due) dq_data_out = pend_val;
    else dq_data_out = pend_val ^ 8'($urandom_range(1, 255));
  end

  always @(negedge clk) begin
    logic [7:0] v;
    if (dq_push && dq_pop) both_hi++;
    if (dq_pop) begin
      pop_total++;
      pop_cyc = cyc;
      pop_sel = dq_deque_select;
      pop_end = dq_end_select;
      v = f_pop_byte;
      if (auto_mode) begin
        v = 8'hEE;
        if (!dq_deque_select) begin
          if (eq0.size() > 0) v = dq_end_select ? eq0.pop_back() : eq0.pop_front();
        end else begin
          if (eq1.size() > 0) v = dq_end_select ? eq1.pop_back() : eq1.pop_front();
        end
      end
      pend_due = cyc + POP_LAT;
      pend_val = v;
    end
    if (dq_push) begin
      push_total++;
      push_cyc = cyc;
      push_sel = dq_deque_select;
      push_end = dq_end_select;
      push_dat = dq_data_in;
      if (auto_mode) begin
        if (!dq_deque_select) begin
          if (eq0.size() < DEPTH) begin
            if (dq_end_select) eq0.push_back(dq_data_in); else eq0.push_front(dq_data_in);
          end
        end else begin
          if (eq1.size() < DEPTH) begin
            if (dq_end_select) eq1.push_back(dq_data_in); else eq1.push_front(dq_data_in);
          end
        end
      end
    end
    if (auto_mode) begin
      d0_empty = (eq0.size() == 0);
      d0_full  = (eq0.size() >= DEPTH);
      d1_empty = (eq1.size() == 0);
      d1_full  = (eq1.size() >= DEPTH);
    end else begin
      d0_empty = f_d0e; d0_full = f_d0f; d1_empty = f_d1e; d1_full = f_d1f;
    end
  end

  // ---------------- command-level reference model ----------------
  logic [7:0] rq0[$];
  logic [7:0] rq1[$];

  function automatic logic [7:0] ref_pop(input logic s, input logic e);
    if (!s) return e ? rq0.pop_back() : rq0.pop_front();
    return e ? rq1.pop_back() : rq1.pop_front();
  endfunction

  function automatic void ref_push(input logic s, input logic e, input logic [7:0] v);
    if (!s) begin
      if (e) rq0.push_back(v); else rq0.push_front(v);
    end else begin
      if (e) rq1.push_back(v); else rq1.push_front(v);
    end
  endfunction

  // ---------------- command driver ----------------
  task automatic run_cmd(input logic [1:0] op, input logic sel, input logic en, input logic ds,
                         input logic de, input logic [7:0] data, input logic exp_err,
                         input logic [7:0] exp_data, input int exp_lat, input int exp_push,
                         input int exp_pop, input int hold, input string tag);
    int   n, acc_cyc, p0, q0, b0;
    logic ok;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_end = en;
    cmd_dst_sel = ds; cmd_dst_end = de; cmd_data = data;
    ok = 1'b0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clk); #1;
      if (cmd_ready) ok = 1'b1; else n++;
    end
    acc_cyc = cyc; p0 = push_total; q0 = pop_total; b0 = both_hi;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_sel = 1'($urandom); cmd_end = 1'($urandom);
    cmd_dst_sel = 1'($urandom); cmd_dst_end = 1'($urandom); cmd_data = 8'($urandom);
    if (!ok) begin
      chk({tag, " accept timeout"}, 32'(cmd_ready), 32'd1);
      return;
    end
    ok = 1'b0; n = 0;
    while (!ok && n < 40) begin
      @(negedge clk); #1;
      if (rsp_valid) ok = 1'b1; else n++;
    end
    if (!ok) begin
      chk({tag, " rsp timeout"}, 32'(rsp_valid), 32'd1);
      return;
    end
    chk({tag, " latency"}, cyc - acc_cyc, exp_lat);
    chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, " data"}, 32'(rsp_data), 32'(exp_data));
    chk({tag, " push count"}, push_total - p0, exp_push);
    chk({tag, " pop count"}, pop_total - q0, exp_pop);
    chk({tag, " push&pop overlap"}, both_hi - b0, 0);
    if (exp_pop > 0) chk({tag, " pop cycle"}, pop_cyc - acc_cyc, 1);
    if (exp_push > 0) chk({tag, " push cycle"}, push_cyc - acc_cyc, (op == 2'd1) ? 1 : 2 + POP_LAT);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      chk({tag, " hold stable"}, {cmd_ready, rsp_valid, rsp_err, rsp_data}, {1'b0, 1'b1, exp_err, exp_data});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk); #1;
    chk({tag, " after handshake"}, {cmd_ready, rsp_valid}, 2'b10);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0] op;
    logic       sel, en, ds, de;
    logic [7:0] data;
    logic [3:0] flags;      // {d0_empty, d0_full, d1_empty, d1_full}
    logic [7:0] pop_byte;
    logic       exp_err;
    logic [7:0] exp_data;
    int         exp_lat, exp_push, exp_pop;
    logic       exp_pop_sel, exp_pop_end, exp_push_sel, exp_push_end;
    logic [7:0] exp_push_dat;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl[NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] op;
    logic sel, en, ds, de, err;
    logic [7:0] data, rd;
    int lat, np, npp, src_n, dst_n;

    tbl[0]  = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 4'b1010, 8'h00, 1'b0, 8'h00, 2, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    tbl[1]  = '{2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'b1010, 8'h11, 1'b1, 8'h00, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 8'h3C, 1'b0, 8'h3C, 2 + POP_LAT, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 4'b0000, 8'h77, 1'b0, 8'h77, 3 + POP_LAT, 1, 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77};
    tbl[4]  = '{2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0100, 8'h5E, 1'b0, 8'h5E, 3 + POP_LAT, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5E};
    tbl[5]  = '{2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0001, 8'h99, 1'b1, 8'h00, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 4'b1010, 8'h22, 1'b0, 8'h00, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 4'b0001, 8'h00, 1'b1, 8'h00, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0010, 8'h44, 1'b1, 8'h00, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0101, 8'hC3, 1'b0, 8'hC3, 2 + POP_LAT, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'b0001, 8'h81, 1'b0, 8'h81, 3 + POP_LAT, 1, 1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h81};
    tbl[11] = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0001, 8'h00, 1'b0, 8'h00, 2, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset ctrl outputs", {cmd_ready, rsp_valid, rsp_err, dq_push, dq_pop, dq_deque_select, dq_end_select}, 7'b0);
    chk("reset data outputs", {rsp_data, dq_data_in}, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("ready before first edge", 32'(cmd_ready), 32'd0);
    @(negedge clk); #1;
    chk("ready after release", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      f_d0e = tbl[i].flags[3]; f_d0f = tbl[i].flags[2];
      f_d1e = tbl[i].flags[1]; f_d1f = tbl[i].flags[0];
      f_pop_byte = tbl[i].pop_byte;
      run_cmd(tbl[i].op, tbl[i].sel, tbl[i].en, tbl[i].ds, tbl[i].de, tbl[i].data,
              tbl[i].exp_err, tbl[i].exp_data, tbl[i].exp_lat, tbl[i].exp_push, tbl[i].exp_pop,
              (i == 0) ? 5 : i % 3, $sformatf("vec%0d", i));
      if (tbl[i].exp_pop > 0)
        chk($sformatf("vec%0d pop sel/end", i), {pop_sel, pop_end}, {tbl[i].exp_pop_sel, tbl[i].exp_pop_end});
      if (tbl[i].exp_push > 0)
        chk($sformatf("vec%0d push sel/end/data", i), {push_sel, push_end, push_dat},
            {tbl[i].exp_push_sel, tbl[i].exp_push_end, tbl[i].exp_push_dat});
    end

    // Reset during WAIT of a POP aborts it without a response
    f_d0e = 1'b0; f_d0f = 1'b0; f_d1e = 1'b0; f_d1f = 1'b0; f_pop_byte = 8'h6D;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_sel = 1'b0; cmd_end = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk); #1;
      if (cmd_ready) break;
      n++;
    end
    chk("rst-abort accept", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst-abort outputs", {dq_push, dq_pop, rsp_valid, cmd_ready}, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) n++;
      if (i == 1) chk("rst-abort ready after release", 32'(cmd_ready), 32'd1);
    end
    chk("rst-abort no response", n, 0);

    // Random commands against environment deques and reference model
    @(posedge clk); #1;
    auto_mode = 1'b1;
    for (int k = 0; k < 200; k++) begin
      n = $urandom_range(0, 9);
      op = (n == 0) ? 2'd0 : (n <= 4) ? 2'd1 : (n <= 7) ? 2'd2 : 2'd3;
      sel = 1'($urandom); en = 1'($urandom); ds = 1'($urandom); de = 1'($urandom);
      data = 8'($urandom);
      src_n = sel ? rq1.size() : rq0.size();
      dst_n = ds ? rq1.size() : rq0.size();
      err = 1'b0; rd = 8'h00; lat = 1; np = 0; npp = 0;
      case (op)
        2'd1: if (src_n >= DEPTH) err = 1'b1;
              else begin lat = 2; np = 1; ref_push(sel, en, data); end
        2'd2: if (src_n == 0) err = 1'b1;
              else begin lat = 2 + POP_LAT; npp = 1; rd = ref_pop(sel, en); end
        2'd3: if (src_n == 0 || (ds != sel && dst_n >= DEPTH)) err = 1'b1;
              else begin
                lat = 3 + POP_LAT; np = 1; npp = 1;
                rd = ref_pop(sel, en);
                ref_push(ds, de, rd);
              end
        default: ;
      endcase
      run_cmd(op, sel, en, ds, de, data, err, rd, lat, np, npp, $urandom_range(0, 2),
              $sformatf("rnd%0d op%0d", k, op));
    end

    chk("final d0 size", eq0.size(), rq0.size());
    chk("final d1 size", eq1.size(), rq1.size());
    for (int i = 0; i < rq0.size() && i < eq0.size(); i++) chk($sformatf("final d0[%0d]", i), 32'(eq0[i]), 32'(rq0[i]));
    for (int i = 0; i < rq1.size() && i < eq1.size(); i++) chk($sformatf("final d1[%0d]", i), 32'(eq1[i]), 32'(rq1[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
